// File: rtl/debug_led_pkg.sv
// Shared types and helpers for the debug LED bar and its prescaler.
package debug_led_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_GRAY  = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_LATCH = 2'd3
  } mode_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debug_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV enabled cycles, with clear and hold.
module debug_tick_gen
  import debug_led_pkg::*;
#(
  parameter int DIV = 8388608
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int CW = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign tick_o    = w_at_last & ~hold_i;

  // Prescaler count; clear wins over hold so a mode change restarts the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (hold_i) begin
      r_cnt <= r_cnt;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/debug_led_bar.sv
// Debug LED bar: count, Gray count, bouncing scanner or latched value, advanced by a prescaled tick.
module debug_led_bar
  import debug_led_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIV        = 8388608,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic             freeze_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_valid_i,
  output logic [WIDTH-1:0] leds_o,
  output logic             tick_o
);

  mode_e            r_mode;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_pat;
  logic             r_dir_down;

  logic             w_mode_chg;
  logic             w_tick;
  logic [WIDTH-1:0] w_bin_inc;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_pat_nxt;
  logic             w_dir_down_nxt;

  assign w_mode_chg = (mode_i != r_mode);
  assign w_bin_inc  = r_bin + WIDTH'(1);

  debug_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_mode_chg),
    .hold_i (freeze_i),
    .tick_o (w_tick)
  );

  // Next pattern state; mode change beats freeze, which beats tick/data_valid.
  always_comb begin
    w_bin_nxt      = r_bin;
    w_pat_nxt      = r_pat;
    w_dir_down_nxt = r_dir_down;
    w_shift        = '0;
    if (w_mode_chg) begin
      w_bin_nxt      = '0;
      w_dir_down_nxt = 1'b0;
      if (mode_e'(mode_i) == MODE_SCAN) begin
        w_pat_nxt = WIDTH'(1);
      end else begin
        w_pat_nxt = '0;
      end
    end else if (freeze_i) begin
      w_pat_nxt = r_pat;
    end else begin
      case (r_mode)
        MODE_COUNT: begin
          if (w_tick) begin
            w_bin_nxt = w_bin_inc;
            w_pat_nxt = w_bin_inc;
          end else begin
            w_bin_nxt = r_bin;
          end
        end
        MODE_GRAY: begin
          if (w_tick) begin
            w_bin_nxt = w_bin_inc;
            w_pat_nxt = w_bin_inc ^ (w_bin_inc >> 1);
          end else begin
            w_bin_nxt = r_bin;
          end
        end
        MODE_SCAN: begin
          // Direction flips on arrival at an end, so each end is shown for one tick.
          if (!w_tick) begin
            w_pat_nxt = r_pat;
          end else if (WIDTH == 1) begin
            w_pat_nxt = WIDTH'(1);
          end else if (!r_dir_down) begin
            w_shift        = r_pat << 1;
            w_pat_nxt      = w_shift;
            w_dir_down_nxt = w_shift[WIDTH-1];
          end else begin
            w_shift        = r_pat >> 1;
            w_pat_nxt      = w_shift;
            w_dir_down_nxt = ~w_shift[0];
          end
        end
        MODE_LATCH: begin
          if (data_valid_i) begin
            w_pat_nxt = data_i;
          end else begin
            w_pat_nxt = r_pat;
          end
        end
        default: begin
          w_pat_nxt = '0;
        end
      endcase
    end
  end

  // Mode and pattern registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= MODE_COUNT;
      r_bin      <= '0;
      r_pat      <= '0;
      r_dir_down <= 1'b0;
    end else begin
      r_mode     <= mode_e'(mode_i);
      r_bin      <= w_bin_nxt;
      r_pat      <= w_pat_nxt;
      r_dir_down <= w_dir_down_nxt;
    end
  end

  assign leds_o = r_pat ^ {WIDTH{ACTIVE_LOW}};
  assign tick_o = w_tick;

endmodule

// File: tb/tb_debug_led_bar.sv
// Directed self-checking bench for debug_led_bar across several parameter sets.
module tb_debug_led_bar;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // u8: WIDTH=8 DIV=4
  logic [1:0] mode8 = 2'd0;
  logic       frz8 = 1'b0, dv8 = 1'b0, tick8;
  logic [7:0] dat8 = 8'h00, leds8;
  // ug: WIDTH=4 DIV=1
  logic [1:0] modeg = 2'd0;
  logic       tickg;
  logic [3:0] datg = 4'h0, ledsg;
  // us: WIDTH=4 DIV=2
  logic [1:0] modes = 2'd0;
  logic       ticks;
  logic [3:0] dats = 4'h0, ledss;
  // u1: WIDTH=1 DIV=2
  logic [1:0] mode1 = 2'd0;
  logic       tick1;
  logic [0:0] dat1 = 1'b0, leds1;
  // ua: WIDTH=8 DIV=4 ACTIVE_LOW
  logic [1:0] modea = 2'd0;
  logic       frza = 1'b0, ticka;
  logic [7:0] data_a = 8'h00, ledsa;
  logic       zero = 1'b0;

  debug_led_bar #(.WIDTH(8), .DIV(4), .ACTIVE_LOW(1'b0)) u8 (
    .clk(clk), .rst(rst), .mode_i(mode8), .freeze_i(frz8), .data_i(dat8),
    .data_valid_i(dv8), .leds_o(leds8), .tick_o(tick8));
  debug_led_bar #(.WIDTH(4), .DIV(1), .ACTIVE_LOW(1'b0)) ug (
    .clk(clk), .rst(rst), .mode_i(modeg), .freeze_i(zero), .data_i(datg),
    .data_valid_i(zero), .leds_o(ledsg), .tick_o(tickg));
  debug_led_bar #(.WIDTH(4), .DIV(2), .ACTIVE_LOW(1'b0)) us (
    .clk(clk), .rst(rst), .mode_i(modes), .freeze_i(zero), .data_i(dats),
    .data_valid_i(zero), .leds_o(ledss), .tick_o(ticks));
  debug_led_bar #(.WIDTH(1), .DIV(2), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst), .mode_i(mode1), .freeze_i(zero), .data_i(dat1),
    .data_valid_i(zero), .leds_o(leds1), .tick_o(tick1));
  debug_led_bar #(.WIDTH(8), .DIV(4), .ACTIVE_LOW(1'b1)) ua (
    .clk(clk), .rst(rst), .mode_i(modea), .freeze_i(frza), .data_i(data_a),
    .data_valid_i(zero), .leds_o(ledsa), .tick_o(ticka));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges; returns just after the last one with rst released.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frz8 = 1'b1;
    step();
    step();
    checks++;
    if (leds8 !== 8'h00) begin errors++; $display("FAIL reset_leds8 got %h exp %h", leds8, 8'h00); end
    checks++;
    if (tick8 !== 1'b0) begin errors++; $display("FAIL reset_tick8 got %b exp 0", tick8); end
    checks++;
    if (ledsa !== 8'hFF) begin errors++; $display("FAIL reset_ledsa got %h exp %h", ledsa, 8'hFF); end
    frz8 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_count();
    logic [7:0] exp_leds;
    logic       exp_tick;
    do_reset();
    for (int n = 1; n <= 1028; n++) begin
      step();
      exp_leds = 8'((n / 4) % 256);
      exp_tick = ((n % 4) == 3);
      checks++;
      if (tick8 !== exp_tick) begin errors++; $display("FAIL count_tick n=%0d got %b exp %b", n, tick8, exp_tick); end
      checks++;
      if (leds8 !== exp_leds) begin errors++; $display("FAIL count_leds n=%0d got %h exp %h", n, leds8, exp_leds); end
      checks++;
      if (ledsa !== ~exp_leds) begin errors++; $display("FAIL count_ledsa n=%0d got %h exp %h", n, ledsa, ~exp_leds); end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    step();
    step();
    frz8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tick8 !== 1'b0 || leds8 !== 8'h00) begin
        errors++; $display("FAIL freeze_hold i=%0d tick %b leds %h exp tick 0 leds 00", i, tick8, leds8);
      end
    end
    frz8 = 1'b0;
    step();
    checks++;
    if (tick8 !== 1'b1) begin errors++; $display("FAIL freeze_resume_tick got %b exp 1", tick8); end
    step();
    checks++;
    if (leds8 !== 8'h01) begin errors++; $display("FAIL freeze_resume_leds got %h exp 01", leds8); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    repeat (223) step();
    checks++;
    if (tick8 !== 1'b1 || leds8 !== 8'h37) begin
      errors++; $display("FAIL switch_pre tick %b leds %h exp tick 1 leds 37", tick8, leds8);
    end
    mode8 = 2'd2;
    step();
    checks++;
    if (leds8 !== 8'h01 || tick8 !== 1'b0) begin
      errors++; $display("FAIL switch_init leds %h tick %b exp leds 01 tick 0", leds8, tick8);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (tick8 !== (i == 3)) begin errors++; $display("FAIL switch_tick i=%0d got %b exp %b", i, tick8, (i == 3)); end
    end
    step();
    checks++;
    if (leds8 !== 8'h02) begin errors++; $display("FAIL switch_scan_step got %h exp 02", leds8); end
  endtask

  task automatic test_latch();
    int nt;
    mode8 = 2'd3;
    step();
    checks++;
    if (leds8 !== 8'h00) begin errors++; $display("FAIL latch_init got %h exp 00", leds8); end
    dat8 = 8'hA5; dv8 = 1'b1;
    step();
    checks++;
    if (leds8 !== 8'hA5) begin errors++; $display("FAIL latch_load got %h exp A5", leds8); end
    frz8 = 1'b1; dat8 = 8'h3C;
    step();
    checks++;
    if (leds8 !== 8'hA5 || tick8 !== 1'b0) begin
      errors++; $display("FAIL latch_frozen leds %h tick %b exp leds A5 tick 0", leds8, tick8);
    end
    frz8 = 1'b0; dv8 = 1'b0;
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick8 === 1'b1) nt++;
      checks++;
      if (leds8 !== 8'hA5) begin errors++; $display("FAIL latch_hold i=%0d got %h exp A5", i, leds8); end
    end
    checks++;
    if (nt !== 2) begin errors++; $display("FAIL latch_tick_count got %0d exp 2", nt); end
  endtask

  task automatic test_gray();
    logic [3:0] tbl [0:16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    modeg = 2'd1;
    step();
    checks++;
    if (ledsg !== 4'h0) begin errors++; $display("FAIL gray_init got %h exp 0", ledsg); end
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (ledsg !== tbl[i]) begin errors++; $display("FAIL gray_seq i=%0d got %h exp %h", i, ledsg, tbl[i]); end
      checks++;
      if ($countones(ledsg ^ tbl[i-1]) != 1) begin
        errors++; $display("FAIL gray_hamming i=%0d got %h prev %h exp distance 1", i, ledsg, tbl[i-1]);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] seq [0:7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    modes = 2'd2;
    mode1 = 2'd2;
    step();
    checks++;
    if (ledss !== seq[0]) begin errors++; $display("FAIL scan_init got %h exp %h", ledss, seq[0]); end
    for (int i = 1; i < 8; i++) begin
      step();
      checks++;
      if (ticks !== 1'b1) begin errors++; $display("FAIL scan_tick i=%0d got %b exp 1", i, ticks); end
      step();
      checks++;
      if (ledss !== seq[i]) begin errors++; $display("FAIL scan_seq i=%0d got %h exp %h", i, ledss, seq[i]); end
      checks++;
      if (leds1 !== 1'b1) begin errors++; $display("FAIL scan_w1 i=%0d got %b exp 1", i, leds1); end
    end
  endtask

  task automatic test_active_low_reset();
    modea = 2'd2;
    step();
    checks++;
    if (ledsa !== 8'hFE) begin errors++; $display("FAIL al_scan_init got %h exp FE", ledsa); end
    repeat (4) step();
    checks++;
    if (ledsa !== 8'hFD) begin errors++; $display("FAIL al_scan_step got %h exp FD", ledsa); end
    frza = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (ledsa !== 8'hFF) begin errors++; $display("FAIL al_midreset got %h exp FF", ledsa); end
    rst = 1'b0;
    frza = 1'b0;
    step();
    checks++;
    if (ledsa !== 8'hFE) begin errors++; $display("FAIL al_mode_after_reset got %h exp FE", ledsa); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_freeze();
    test_mode_switch();
    test_latch();
    test_gray();
    test_scan();
    test_active_low_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
